// File: rtl/alarm_ctrl.sv
// Alarm ring-session sequencer on the 1 Hz clock: turns the minute-long time
// match into one ring session with stop, limited snooze, auto-timeout and day mask.
module alarm_ctrl #(
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter logic [6:0]  DAY_MASK   = 7'b0011111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_match,
  input  logic       alarm_on,
  input  logic       min_tick,
  input  logic [2:0] day,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzz,
  output logic [1:0] state,
  output logic [5:0] snooze_left,
  output logic [2:0] snooze_cnt
);

  localparam int unsigned RING_W = 8;
  localparam int unsigned LEFT_W = 6;
  localparam int unsigned CNT_W  = 3;

  // Day 7 does not exist; the extra zero bit masks it.
  localparam logic [7:0] DAY_MASK_EXT = {1'b0, DAY_MASK};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RING_W-1:0]   r_ring_cnt;
  logic [RING_W-1:0]   w_ring_cnt_nxt;
  logic [LEFT_W-1:0]   r_snooze_left;
  logic [LEFT_W-1:0]   w_snooze_left_nxt;
  logic [CNT_W-1:0]    r_snooze_cnt;
  logic [CNT_W-1:0]    w_snooze_cnt_nxt;
  logic                r_buzz;
  logic                w_day_ok;

  assign w_day_ok = DAY_MASK_EXT[day];

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_ring_cnt    <= '0;
      r_snooze_left <= '0;
      r_snooze_cnt  <= '0;
      r_buzz        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ring_cnt    <= w_ring_cnt_nxt;
      r_snooze_left <= w_snooze_left_nxt;
      r_snooze_cnt  <= w_snooze_cnt_nxt;
      r_buzz        <= (w_state_nxt == ST_RING);
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_nxt       = r_state;
    w_ring_cnt_nxt    = r_ring_cnt;
    w_snooze_left_nxt = r_snooze_left;
    w_snooze_cnt_nxt  = r_snooze_cnt;

    case (r_state)
      ST_IDLE: begin
        if (alarm_match && alarm_on && w_day_ok) begin
          w_state_nxt      = ST_RING;
          w_ring_cnt_nxt   = '0;
          w_snooze_cnt_nxt = '0;
        end
      end

      ST_RING: begin
        if (stop_btn || !alarm_on) begin
          w_state_nxt = ST_DONE;
        end else if (snooze_btn) begin
          // Snooze past the session limit acts as a dismiss.
          if (r_snooze_cnt < CNT_W'(MAX_SNOOZE)) begin
            w_state_nxt       = ST_SNOOZE;
            w_snooze_left_nxt = LEFT_W'(SNOOZE_MIN);
            w_snooze_cnt_nxt  = r_snooze_cnt + CNT_W'(1);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else if (r_ring_cnt == RING_W'(RING_SEC - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ring_cnt_nxt = r_ring_cnt + RING_W'(1);
        end
      end

      ST_SNOOZE: begin
        if (stop_btn || !alarm_on) begin
          w_state_nxt = ST_DONE;
        end else if (min_tick) begin
          // Expiry rings regardless of day or match.
          if (r_snooze_left == LEFT_W'(1)) begin
            w_state_nxt       = ST_RING;
            w_ring_cnt_nxt    = '0;
            w_snooze_left_nxt = '0;
          end else if (r_snooze_left > LEFT_W'(1)) begin
            w_snooze_left_nxt = r_snooze_left - LEFT_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (!alarm_match) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign buzz        = r_buzz;
  assign state       = r_state;
  assign snooze_left = r_snooze_left;
  assign snooze_cnt  = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: a session-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_alarm_ctrl;

  localparam int unsigned SNOOZE_MIN = 9;
  localparam int unsigned RING_SEC   = 60;
  localparam int unsigned MAX_SNOOZE = 3;
  localparam logic [6:0]  DAY_MASK   = 7'b0011111;

  localparam int MD_IDLE   = 0;
  localparam int MD_RING   = 1;
  localparam int MD_SNOOZE = 2;
  localparam int MD_DONE   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alarm_match = 1'b1;
  logic       alarm_on = 1'b1;
  logic       min_tick = 1'b0;
  logic [2:0] day = 3'd2;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzz;
  logic [1:0] state;
  logic [5:0] snooze_left;
  logic [2:0] snooze_cnt;

  int n_checks = 0;
  int n_err    = 0;

  alarm_ctrl #(
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_SEC  (RING_SEC),
    .MAX_SNOOZE(MAX_SNOOZE),
    .DAY_MASK  (DAY_MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_match(alarm_match),
    .alarm_on   (alarm_on),
    .min_tick   (min_tick),
    .day        (day),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzz       (buzz),
    .state      (state),
    .snooze_left(snooze_left),
    .snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Session model: what mode we are in, seconds rung, minutes of snooze left, snoozes used.
  int m_mode    = MD_IDLE;
  int m_rung    = 0;
  int m_minutes = 0;
  int m_used    = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = MD_IDLE; m_rung = 0; m_minutes = 0; m_used = 0;
    end else begin
      case (m_mode)
        MD_IDLE: begin
          if (alarm_match && alarm_on && (((DAY_MASK >> day) & 7'd1) != 0)) begin
            m_mode = MD_RING; m_rung = 0; m_used = 0;
          end
        end
        MD_RING: begin
          if (stop_btn || !alarm_on) m_mode = MD_DONE;
          else if (snooze_btn && m_used >= int'(MAX_SNOOZE)) m_mode = MD_DONE;
          else if (snooze_btn) begin
            m_mode = MD_SNOOZE; m_minutes = int'(SNOOZE_MIN); m_used = m_used + 1;
          end else if (m_rung + 1 >= int'(RING_SEC)) m_mode = MD_DONE;
          else m_rung = m_rung + 1;
        end
        MD_SNOOZE: begin
          if (stop_btn || !alarm_on) m_mode = MD_DONE;
          else if (min_tick) begin
            m_minutes = m_minutes - 1;
            if (m_minutes == 0) begin
              m_mode = MD_RING; m_rung = 0;
            end
          end
        end
        default: begin
          if (!alarm_match) m_mode = MD_IDLE;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_buzz",  int'(buzz),        (m_mode == MD_RING) ? 1 : 0);
    chk("model_state", int'(state),       m_mode);
    chk("model_left",  int'(snooze_left), m_minutes);
    chk("model_cnt",   int'(snooze_cnt),  m_used);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1; tick(1); snooze_btn = 1'b0;
  endtask

  task automatic expire_snooze();
    for (int k = 0; k < int'(SNOOZE_MIN); k++) begin
      min_tick = 1'b1; tick(1);
    end
    min_tick = 1'b0;
  endtask

  initial begin
    int nbuzz;
    // 1: reset with match held
    #12;
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    chk("t1_state", int'(state), 1);
    chk("t1_buzz", int'(buzz), 1);

    // 2: stop, hold while matched, no re-ring
    tick(4);
    stop_btn = 1'b1; tick(1); stop_btn = 1'b0;
    chk("t2_stop_state", int'(state), 3);
    chk("t2_stop_buzz", int'(buzz), 0);
    tick(55);
    chk("t2_hold", int'(state), 3);
    alarm_match = 1'b0; tick(1);
    chk("t2_idle", int'(state), 0);
    tick(3);
    chk("t2_no_rering", int'(buzz), 0);

    // 3: snooze and expiry
    alarm_match = 1'b1; tick(1);
    chk("t3_ring", int'(state), 1);
    alarm_match = 1'b0;
    press_snooze();
    chk("t3_state", int'(state), 2);
    chk("t3_left", int'(snooze_left), 9);
    chk("t3_cnt", int'(snooze_cnt), 1);
    for (int k = 1; k <= 9; k++) begin
      min_tick = 1'b1; tick(1); min_tick = 1'b0;
      if (k < 9) chk("t3_countdown", int'(snooze_left), 9 - k);
      else begin
        chk("t3_rering_state", int'(state), 1);
        chk("t3_rering_buzz", int'(buzz), 1);
        chk("t3_rering_left", int'(snooze_left), 0);
      end
      tick(1);
    end

    // 4: snooze limit and stop-over-snooze
    press_snooze(); expire_snooze();
    press_snooze(); expire_snooze();
    chk("t4_cnt3", int'(snooze_cnt), 3);
    chk("t4_ring", int'(state), 1);
    press_snooze();
    chk("t4_limit_state", int'(state), 3);
    chk("t4_limit_cnt", int'(snooze_cnt), 3);
    tick(1);
    chk("t4_idle", int'(state), 0);
    alarm_match = 1'b1; tick(1);
    chk("t4_ring2", int'(state), 1);
    chk("t4_cnt_clr", int'(snooze_cnt), 0);
    stop_btn = 1'b1; snooze_btn = 1'b1; tick(1);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("t4_both_state", int'(state), 3);
    chk("t4_both_cnt", int'(snooze_cnt), 0);

    // 5: day mask and auto-timeout
    alarm_match = 1'b0; tick(1);
    day = 3'd5; alarm_match = 1'b1; tick(3);
    chk("t5_mask_state", int'(state), 0);
    chk("t5_mask_buzz", int'(buzz), 0);
    day = 3'd7; tick(2);
    chk("t5_day7", int'(state), 0);
    day = 3'd4;
    nbuzz = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (buzz) nbuzz++;
      else break;
    end
    chk("t5_buzz_len", nbuzz, 60);
    chk("t5_timeout", int'(state), 3);

    // 6: alarm_on drop in snooze, async reset mid-ring
    alarm_match = 1'b0; tick(1);
    alarm_match = 1'b1; tick(1);
    press_snooze();
    alarm_on = 1'b0; tick(1);
    chk("t6_off_state", int'(state), 3);
    alarm_on = 1'b1; alarm_match = 1'b0; tick(1);
    alarm_match = 1'b1; tick(1);
    press_snooze(); expire_snooze();
    tick(2);
    chk("t6_pre_buzz", int'(buzz), 1);
    chk("t6_pre_cnt", int'(snooze_cnt), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_buzz", int'(buzz), 0);
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_cnt", int'(snooze_cnt), 0);
    chk("t6_rst_left", int'(snooze_left), 0);
    alarm_match = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    chk("t6_after", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm sequencing controller between the alarm time comparator and the buzzer output of the weekday alarm clock. It turns the comparator's minute-long match level into a one-shot ring session. The session supports stop, snooze with a per-session snooze limit, auto-timeout and a weekday mask. It runs on the 1 Hz clock, so one cycle equals one second, and replaces the combinational Buzz gating at the top level.

Parameters:
SNOOZE_MIN, 9, snooze length in minutes (1..59)
RING_SEC, 60, ring cycles before auto-off (2..255)
MAX_SNOOZE, 3, snoozes allowed per session (1..7)
DAY_MASK, 7'b0011111, bit d=1 lets day d (0..6) start a session; default suppresses days 5,6

Ports:
clk  input  1  1 Hz clock (Pulse)
rst  input  1  asynchronous, active-low reset
alarm_match  input  1  high while TMin==AMin and THrs==AHrs
alarm_on  input  1  alarm enable switch
min_tick  input  1  one-cycle pulse when seconds wrap 59->0 (Szero)
day  input  3  current day 0..6
snooze_btn  input  1  snooze request, level-sampled each cycle
stop_btn  input  1  dismiss request, level-sampled each cycle
buzz  output  1  buzzer drive
state  output  2  0 IDLE, 1 RING, 2 SNOOZE, 3 DONE
snooze_left  output  6  minutes remaining in snooze
snooze_cnt  output  3  snoozes used this session

Behaviour:
- Reset (rst=0, async): state=IDLE, buzz=0, snooze_left=0, snooze_cnt=0, ring counter=0. Reset asserted mid-ring drops buzz immediately.
- buzz = (state==RING), decoded from the state register. Latency is 1 cycle from the qualifying input to buzz.
- IDLE:
  - alarm_match & alarm_on & DAY_MASK[day] -> RING; clear ring counter and snooze_cnt.
  - day values 7 are treated as masked.
- RING, evaluated in priority order:
  - stop_btn -> DONE.
  - !alarm_on -> DONE.
  - snooze_btn & snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_left=SNOOZE_MIN; snooze_cnt+1.
  - snooze_btn & snooze_cnt==MAX_SNOOZE -> DONE (treated as stop).
  - ring counter==RING_SEC-1 -> DONE (auto-off). Otherwise the ring counter increments.
  - Stop and snooze in the same cycle: stop wins.
- SNOOZE:
  - stop_btn or !alarm_on -> DONE.
  - min_tick with snooze_left==1 -> RING; clear ring counter; snooze_left=0.
  - min_tick otherwise -> snooze_left-1.
  - snooze_btn is ignored.
  - Snooze expiry rings regardless of day and of alarm_match (crossing midnight into a masked day still rings).
- DONE:
  - !alarm_match -> IDLE; else hold.
  - This prevents re-triggering within the matched minute after a dismiss or timeout.
- snooze_left and snooze_cnt hold their values in DONE and IDLE. snooze_cnt clears only on IDLE->RING or reset.
- Widths:
  - Ring counter is 8 bits, saturating is not needed (bounded by RING_SEC).
  - snooze_left never underflows; a decrement happens only when it is >1.
- min_tick coinciding with a state transition out of SNOOZE is ignored.

Test Plan:
1. Reset low with alarm_match=1 -> buzz=0, state=0. Release reset with alarm_on=1, day=2, match=1 -> next cycle state=1, buzz=1.
2. Ringing, stop_btn pulsed at cycle 5 -> state=3, buzz=0 next cycle. match held 55 more cycles -> stays 3; match drops -> state=0, no re-ring.
3. Ringing, snooze_btn -> state=2, snooze_left=9, snooze_cnt=1. Nine min_tick pulses -> snooze_left 8..1, then state=1, buzz=1.
4. Snooze three times, then snooze_btn on the fourth ring -> state=3 (snooze_cnt stays 3). stop+snooze in the same cycle -> state=3.
5. day=5, match=1, alarm_on=1 -> state remains 0, buzz=0. day=4 -> rings. No buttons pressed -> buzz high exactly 60 cycles, then state=3.
6. alarm_on dropped during SNOOZE -> state=3. rst asserted mid-RING -> buzz=0 asynchronously and all outputs reset.
